// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction sequencer and 4-entry operand register file in
// front of the field ALU. One instruction (ADD, MUL, SQR, LOAD) is accepted at
// a time. Source operands are registered onto the ALU buses and the ALU result
// is written back to the destination register. MUL waits for the multiplier's
// done signal, and a watchdog gives up after TMO cycles.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   ins_valid/ins_ready  instruction handshake (ready only in IDLE)
//   ins_op               00 ADD, 01 MUL, 10 SQR, 11 LOAD
//   ins_rd/ra/rb         destination / source A / source B register index
//   ins_data             LOAD immediate
//   rd_sel, rd_data      combinational register read port
//   alu_a, alu_b         registered ALU operands
//   alu_ss/st/sy         registered ALU selects
//   alu_m_start          one-cycle multiplier start pulse
//   alu_y, alu_m_done    ALU result, multiplier completion
//   done, err            completion pulse; err marks a MUL timeout
module alu_sequencer #(
  parameter int unsigned W   = 163,
  parameter int unsigned TMO = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ins_valid,
  output logic         ins_ready,
  input  logic [1:0]   ins_op,
  input  logic [1:0]   ins_rd,
  input  logic [1:0]   ins_ra,
  input  logic [1:0]   ins_rb,
  input  logic [W-1:0] ins_data,
  input  logic [1:0]   rd_sel,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_ss,
  output logic         alu_st,
  output logic         alu_sy,
  output logic         alu_m_start,
  input  logic [W-1:0] alu_y,
  input  logic         alu_m_done,
  output logic         done,
  output logic         err
);

  // Counter only has to hold values up to TMO-1.
  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_SQR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXEC   = 2'b01,
    S_MSTART = 2'b10,
    S_MWAIT  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [3:0][W-1:0] regs_q, regs_d;
  logic [W-1:0]      imm_q, imm_d;
  op_e               op_q, op_d;
  logic [1:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      alu_a_d, alu_b_d;
  logic              alu_ss_d, alu_st_d, alu_sy_d;
  logic              alu_m_start_d, done_d, err_d;

  assign ins_ready = (state_q == S_IDLE);
  assign rd_data   = regs_q[rd_sel];

  // Next-state, writeback and registered-output decode.
  always_comb begin
    state_d       = state_q;
    regs_d        = regs_q;
    imm_d         = imm_q;
    op_d          = op_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a;
    alu_b_d       = alu_b;
    alu_ss_d      = alu_ss;
    alu_st_d      = alu_st;
    alu_sy_d      = alu_sy;
    alu_m_start_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ins_valid) begin
          // Operands come from regs_q, so a same-edge write never leaks in.
          alu_a_d = regs_q[ins_ra];
          alu_b_d = regs_q[ins_rb];
          op_d    = op_e'(ins_op);
          rd_d    = ins_rd;
          case (op_e'(ins_op))
            OP_ADD: begin
              alu_st_d = 1'b1;
              alu_sy_d = 1'b0;
              state_d  = S_EXEC;
            end
            OP_MUL: begin
              alu_st_d      = 1'b0;
              alu_sy_d      = 1'b0;
              alu_m_start_d = 1'b1;
              state_d       = S_MSTART;
            end
            OP_SQR: begin
              alu_ss_d = 1'b1;
              alu_sy_d = 1'b1;
              state_d  = S_EXEC;
            end
            default: begin
              imm_d   = ins_data;
              state_d = S_EXEC;
            end
          endcase
        end
      end

      S_EXEC: begin
        regs_d[rd_q] = (op_q == OP_LOAD) ? imm_q : alu_y;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end

      S_MSTART: begin
        cnt_d   = '0;
        state_d = S_MWAIT;
      end

      S_MWAIT: begin
        if (alu_m_done) begin
          regs_d[rd_q] = alu_y;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          // Watchdog expired: complete with error, leave destination alone.
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      regs_q      <= '0;
      imm_q       <= '0;
      op_q        <= OP_ADD;
      rd_q        <= 2'd0;
      cnt_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ss      <= 1'b1;
      alu_st      <= 1'b0;
      alu_sy      <= 1'b0;
      alu_m_start <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_ss      <= alu_ss_d;
      alu_st      <= alu_st_d;
      alu_sy      <= alu_sy_d;
      alu_m_start <= alu_m_start_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a GF(2) ALU model
// (XOR adder, carry-less squarer, carry-less multiplier with 10-cycle latency).
module tb_alu_sequencer;

  localparam int unsigned W   = 163;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ins_valid;
  logic         ins_ready;
  logic [1:0]   ins_op, ins_rd, ins_ra, ins_rb, rd_sel;
  logic [W-1:0] ins_data, rd_data, alu_a, alu_b, alu_y;
  logic         alu_ss, alu_st, alu_sy, alu_m_start, alu_m_done, done, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
    .ins_rd(ins_rd), .ins_ra(ins_ra), .ins_rb(ins_rb), .ins_data(ins_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ss(alu_ss), .alu_st(alu_st), .alu_sy(alu_sy),
    .alu_m_start(alu_m_start), .alu_y(alu_y), .alu_m_done(alu_m_done),
    .done(done), .err(err)
  );

  // Carry-less product of small operands (no field reduction needed here).
  function automatic logic [W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) r = r ^ (a << i);
    return r;
  endfunction

  // Multiplier model: done 10 cycles after start unless disabled.
  logic [4:0]   mcnt;
  logic         m_done_mdl, mul_enable, late_done;
  logic [W-1:0] mul_y;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt       <= 5'd0;
      m_done_mdl <= 1'b0;
      mul_y      <= '0;
    end else begin
      m_done_mdl <= 1'b0;
      if (alu_m_start) begin
        mcnt  <= 5'd10;
        mul_y <= clmul(alu_a, alu_b);
      end else if (mcnt != 5'd0) begin
        mcnt <= mcnt - 5'd1;
        if (mcnt == 5'd1 && mul_enable) m_done_mdl <= 1'b1;
      end
    end
  end

  assign alu_m_done = m_done_mdl | late_done;
  assign alu_y = alu_sy ? clmul(alu_a, alu_a) : (alu_st ? (alu_a ^ alu_b) : mul_y);

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, input logic [W-1:0] exp, input string tag);
    rd_sel = idx;
    #1;
    check(tag, rd_data, exp);
  endtask

  // Present one instruction at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [W-1:0] data, input string tag);
    int n;
    n = 0;
    while (!ins_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_before"}, W'(ins_ready), W'(1));
    ins_valid = 1'b1;
    ins_op = op; ins_rd = rd; ins_ra = ra; ins_rb = rb; ins_data = data;
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  // ADD/SQR/LOAD: one EXEC cycle, done and result in the cycle after.
  task automatic run_simple(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                            input logic [1:0] rb, input logic [W-1:0] data,
                            input logic [W-1:0] exp_a, input logic exp_st, input logic exp_sy,
                            input logic [W-1:0] exp_res, input string tag);
    issue(op, rd, ra, rb, data, tag);
    check({tag, "_exec_ready"}, W'(ins_ready), W'(0));
    check({tag, "_exec_done"},  W'(done), W'(0));
    check({tag, "_exec_a"},     alu_a, exp_a);
    check({tag, "_exec_st"},    W'(alu_st), W'(exp_st));
    check({tag, "_exec_sy"},    W'(alu_sy), W'(exp_sy));
    check({tag, "_exec_ss"},    W'(alu_ss), W'(1));
    @(negedge clk);
    check({tag, "_done"},       W'(done), W'(1));
    check({tag, "_err"},        W'(err), W'(0));
    check({tag, "_ready_back"}, W'(ins_ready), W'(1));
    read_reg(rd, exp_res, {tag, "_result"});
    @(negedge clk);
    check({tag, "_done_width"}, W'(done), W'(0));
  endtask

  int  n, starts, lat;
  bit  seen_done, prev_mdone, ab_ok, seen_err;

  initial begin
    rst = 1'b1; ins_valid = 1'b0; ins_op = 2'b00; ins_rd = 2'd0; ins_ra = 2'd0;
    ins_rb = 2'd0; ins_data = '0; rd_sel = 2'd0; mul_enable = 1'b1; late_done = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_ready", W'(ins_ready), W'(1));
    check("rst_ss", W'(alu_ss), W'(1));
    check("rst_st", W'(alu_st), W'(0));
    check("rst_sy", W'(alu_sy), W'(0));
    check("rst_start", W'(alu_m_start), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_a", alu_a, '0);
    check("rst_b", alu_b, '0);
    for (int i = 0; i < 4; i++) read_reg(2'(i), '0, "rst_reg");
    rst = 1'b0;
    @(negedge clk);

    // LOAD, ADD (XOR), SQR (carry-less square)
    run_simple(2'b11, 2'd0, 2'd0, 2'd0, W'(5), W'(0), 1'b0, 1'b0, W'(5), "load_r0");
    run_simple(2'b11, 2'd1, 2'd0, 2'd0, W'(3), W'(5), 1'b0, 1'b0, W'(3), "load_r1");
    read_reg(2'd0, W'(5), "read_r0");
    read_reg(2'd1, W'(3), "read_r1");
    run_simple(2'b00, 2'd2, 2'd0, 2'd1, '0, W'(5), 1'b1, 1'b0, W'(6), "add_r2");
    run_simple(2'b10, 2'd3, 2'd1, 2'd1, '0, W'(3), 1'b1, 1'b1, W'(5), "sqr_r3");

    // MUL r2 = r0*r1 while ins_valid stays high with changing fields
    issue(2'b01, 2'd2, 2'd0, 2'd1, '0, "mul");
    check("mul_start", W'(alu_m_start), W'(1));
    check("mul_st", W'(alu_st), W'(0));
    check("mul_sy", W'(alu_sy), W'(0));
    ins_valid = 1'b1;
    starts = 1; n = 0; seen_done = 1'b0; prev_mdone = 1'b0; ab_ok = 1'b1;
    while (!seen_done && n < 60) begin
      ins_op = n[0] ? 2'b11 : 2'b00;
      ins_rd = 2'(n); ins_ra = 2'(n + 1); ins_rb = 2'(n + 2);
      ins_data = W'(32'h100 + n);
      prev_mdone = alu_m_done;
      @(negedge clk);
      n++;
      if (alu_m_start) starts++;
      if (alu_a !== W'(5) || alu_b !== W'(3)) ab_ok = 1'b0;
      if (done) seen_done = 1'b1;
    end
    check("mul_done_seen", W'(seen_done), W'(1));
    check("mul_start_once", W'(starts), W'(1));
    check("mul_ab_stable", W'(ab_ok), W'(1));
    check("mul_done_after_mdone", W'(prev_mdone), W'(1));
    check("mul_err", W'(err), W'(0));
    check("mul_ready_at_done", W'(ins_ready), W'(1));
    read_reg(2'd2, W'(15), "mul_r2");
    read_reg(2'd0, W'(5), "mul_r0_kept");
    read_reg(2'd1, W'(3), "mul_r1_kept");
    read_reg(2'd3, W'(5), "mul_r3_kept");
    // Instruction still held at the done cycle is taken on the next edge
    ins_op = 2'b11; ins_rd = 2'd3; ins_ra = 2'd0; ins_rb = 2'd0; ins_data = W'(32'h77);
    @(negedge clk);
    ins_valid = 1'b0;
    check("b2b_accepted", W'(ins_ready), W'(0));
    check("b2b_done_clear", W'(done), W'(0));
    @(negedge clk);
    check("b2b_done", W'(done), W'(1));
    read_reg(2'd3, W'(32'h77), "b2b_r3");
    @(negedge clk);

    // MUL timeout with alu_m_done held low
    mul_enable = 1'b0;
    issue(2'b01, 2'd1, 2'd0, 2'd0, '0, "tmo");
    lat = 0; seen_done = 1'b0; seen_err = 1'b0;
    while (!seen_done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) begin seen_done = 1'b1; seen_err = err; end
    end
    check("tmo_done", W'(seen_done), W'(1));
    check("tmo_err", W'(seen_err), W'(1));
    check("tmo_latency_ok", W'(lat >= int'(TMO) && lat <= int'(TMO) + 2), W'(1));
    read_reg(2'd1, W'(3), "tmo_dest_kept");
    @(negedge clk);
    check("tmo_err_width", W'(err), W'(0));
    check("tmo_done_width", W'(done), W'(0));
    mul_enable = 1'b1;
    run_simple(2'b11, 2'd1, 2'd0, 2'd0, W'(9), W'(5), 1'b0, 1'b0, W'(9), "load_after_tmo");

    // Reset in the middle of MWAIT, then a late alu_m_done
    issue(2'b01, 2'd3, 2'd0, 2'd1, '0, "rst_mul");
    repeat (4) @(negedge clk);
    check("rst_mul_busy", W'(ins_ready), W'(0));
    rst = 1'b1;
    #1;
    check("rst_async_ready", W'(ins_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || err) seen_done = 1'b1;
    end
    check("rst_no_done", W'(seen_done), W'(0));
    check("rst_idle", W'(ins_ready), W'(1));
    check("rst_ss_again", W'(alu_ss), W'(1));
    check("rst_a_again", alu_a, '0);
    for (int i = 0; i < 4; i++) read_reg(2'(i), '0, "rst_reg_clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
